// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per cycle.
// Optional build macro SEQ_BIN2BCD_SIGNED_EN: two's-complement input with a NEG result flag.
module seq_bin2bcd #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
`ifdef SEQ_BIN2BCD_SIGNED_EN
    output logic                  neg,
`endif
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH);
    localparam int BW    = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [BW-1:0]        digits_q;
    logic                 ovf_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_q;
    logic [BIN_WIDTH-1:0] mag;
    logic [BW-1:0]        adj;
    logic [BW-1:0]        digits_step;
    logic                 carry;
`ifdef SEQ_BIN2BCD_SIGNED_EN
    logic                 neg_q;
`endif

    // NOTE: every combinational output gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_q)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef SEQ_BIN2BCD_SIGNED_EN
        mag = bin[BIN_WIDTH-1] ? (~bin + BIN_WIDTH'(1)) : bin;
`else
        mag = bin;
`endif
        adj = digits_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        carry       = adj[BW-1];
        digits_step = {adj[BW-2:0], shift_q[BIN_WIDTH-1]};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The extra SHIFT cycle after the last bit (last_q) publishes the result on the edge entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
`ifdef SEQ_BIN2BCD_SIGNED_EN
            neg_q    <= 1'b0;
            neg      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q  <= mag;
                        digits_q <= '0;
                        ovf_q    <= 1'b0;
                        cnt_q    <= CNT_W'(BIN_WIDTH - 1);
                        last_q   <= 1'b0;
`ifdef SEQ_BIN2BCD_SIGNED_EN
                        neg_q    <= bin[BIN_WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    if (!last_q) begin
                        digits_q <= digits_step;
                        ovf_q    <= ovf_q | carry;
                        shift_q  <= {shift_q[BIN_WIDTH-2:0], 1'b0};
                        if (cnt_q == '0) last_q <= 1'b1;
                        else             cnt_q  <= cnt_q - CNT_W'(1);
                    end else begin
                        bcd      <= digits_q;
                        overflow <= ovf_q;
`ifdef SEQ_BIN2BCD_SIGNED_EN
                        neg      <= neg_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd: four parameterisations, directed table, corner sequences, random sweep.
// Honours SEQ_BIN2BCD_SIGNED_EN when the design is built with it.
module tb_seq_bin2bcd;

    localparam int NI = 4;
    localparam int W_A [NI] = '{16, 16, 8, 32};
    localparam int D_A [NI] = '{5, 4, 2, 9};

    typedef struct {
        int          k;
        logic [31:0] v;
        logic [39:0] bcd;
        logic        ovf;
        logic        neg;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [NI-1:0]     in_valid_a;
    logic [NI-1:0]     out_ready_a;
    logic [31:0]       bin_a [NI];
    wire  [NI-1:0]     in_ready_a;
    wire  [NI-1:0]     out_valid_a;
    wire  [NI-1:0]     overflow_a;
    wire  [19:0]       bcd0;
    wire  [15:0]       bcd1;
    wire  [7:0]        bcd2;
    wire  [35:0]       bcd3;
    logic [39:0]       bcd_a [NI];
`ifdef SEQ_BIN2BCD_SIGNED_EN
    wire  [NI-1:0]     neg_a;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    assign bcd_a[0] = {20'd0, bcd0};
    assign bcd_a[1] = {24'd0, bcd1};
    assign bcd_a[2] = {32'd0, bcd2};
    assign bcd_a[3] = {4'd0, bcd3};

    seq_bin2bcd #(.BIN_WIDTH(16), .DIGITS(5)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .bin(bin_a[0][15:0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .bcd(bcd0),
`ifdef SEQ_BIN2BCD_SIGNED_EN
        .neg(neg_a[0]),
`endif
        .overflow(overflow_a[0]));

    seq_bin2bcd #(.BIN_WIDTH(16), .DIGITS(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .bin(bin_a[1][15:0]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .bcd(bcd1),
`ifdef SEQ_BIN2BCD_SIGNED_EN
        .neg(neg_a[1]),
`endif
        .overflow(overflow_a[1]));

    seq_bin2bcd #(.BIN_WIDTH(8), .DIGITS(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .bin(bin_a[2][7:0]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .bcd(bcd2),
`ifdef SEQ_BIN2BCD_SIGNED_EN
        .neg(neg_a[2]),
`endif
        .overflow(overflow_a[2]));

    seq_bin2bcd #(.BIN_WIDTH(32), .DIGITS(9)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
        .bin(bin_a[3]), .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]),
        .bcd(bcd3),
`ifdef SEQ_BIN2BCD_SIGNED_EN
        .neg(neg_a[3]),
`endif
        .overflow(overflow_a[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input int k, input logic [31:0] v, input logic [39:0] b,
                                 input logic o, input logic n);
        mkv.k = k; mkv.v = v; mkv.bcd = b; mkv.ovf = o; mkv.neg = n;
    endfunction

    // Reference: plain integer arithmetic on the value, decimal digits by division.
    function automatic void model(input int k, input logic [31:0] v, output logic [39:0] e_bcd,
                                  output logic e_ovf, output logic e_neg);
        longint unsigned m, lim;
        m     = 64'(v) & ((64'd1 << W_A[k]) - 64'd1);
        e_neg = 1'b0;
`ifdef SEQ_BIN2BCD_SIGNED_EN
        if (m >= (64'd1 << (W_A[k] - 1))) begin
            e_neg = 1'b1;
            m     = (64'd1 << W_A[k]) - m;
        end
`endif
        lim = 1;
        for (int d = 0; d < D_A[k]; d++) lim = lim * 10;
        e_ovf = (m >= lim);
        m     = m % lim;
        e_bcd = '0;
        for (int i = 0; i < D_A[k]; i++) begin
            e_bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    task automatic accept(input int k, input logic [31:0] v);
        @(negedge clk);
        check($sformatf("in_ready_before_accept[%0d]", k), 64'(in_ready_a[k]), 64'd1);
        in_valid_a[k] = 1'b1;
        bin_a[k]      = v;
        @(posedge clk);
        #1;
        in_valid_a[k] = 1'b0;
        bin_a[k]      = $urandom;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!out_valid_a[k] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input int k);
        @(negedge clk);
        out_ready_a[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[k] = 1'b0;
        check($sformatf("out_valid_after_handshake[%0d]", k), 64'(out_valid_a[k]), 64'd0);
    endtask

    task automatic run_vec(input vec_t t, input int hold, input string tag);
        int lat;
        accept(t.k, t.v);
        wait_done(t.k, lat);
        check($sformatf("%s_latency k%0d v%0h", tag, t.k, t.v), 64'(lat), 64'(W_A[t.k] + 1));
        repeat (hold) @(posedge clk);
        #1;
        check($sformatf("%s_bcd k%0d v%0h", tag, t.k, t.v), 64'(bcd_a[t.k]), 64'(t.bcd));
        check($sformatf("%s_ovf k%0d v%0h", tag, t.k, t.v), 64'(overflow_a[t.k]), 64'(t.ovf));
`ifdef SEQ_BIN2BCD_SIGNED_EN
        check($sformatf("%s_neg k%0d v%0h", tag, t.k, t.v), 64'(neg_a[t.k]), 64'(t.neg));
`endif
        handshake(t.k);
    endtask

    initial begin
        int   lat;
        vec_t t;
        in_valid_a  = '0;
        out_ready_a = '0;
        for (int i = 0; i < NI; i++) bin_a[i] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_in_ready[%0d]", i), 64'(in_ready_a[i]), 64'd1);
            check($sformatf("reset_out_valid[%0d]", i), 64'(out_valid_a[i]), 64'd0);
            check($sformatf("reset_bcd[%0d]", i), 64'(bcd_a[i]), 64'd0);
            check($sformatf("reset_ovf[%0d]", i), 64'(overflow_a[i]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SEQ_BIN2BCD_SIGNED_EN
        vecs.push_back(mkv(0, 32'h8000,     40'h32768,     1'b0, 1'b1));
        vecs.push_back(mkv(0, 32'hFFFF,     40'h00001,     1'b0, 1'b1));
        vecs.push_back(mkv(0, 32'h0,        40'h0,         1'b0, 1'b0));
        vecs.push_back(mkv(0, 32'h7FFF,     40'h32767,     1'b0, 1'b0));
        vecs.push_back(mkv(1, 32'h8000,     40'h2768,      1'b1, 1'b1));
        vecs.push_back(mkv(2, 32'h80,       40'h28,        1'b1, 1'b1));
        vecs.push_back(mkv(2, 32'h7F,       40'h27,        1'b1, 1'b0));
        vecs.push_back(mkv(2, 32'hF6,       40'h10,        1'b0, 1'b1));
        vecs.push_back(mkv(3, 32'h80000000, 40'h147483648, 1'b1, 1'b1));
        vecs.push_back(mkv(3, 32'hFFFFFFFF, 40'h1,         1'b0, 1'b1));
`else
        vecs.push_back(mkv(0, 32'd65535,      40'h65535,     1'b0, 1'b0));
        vecs.push_back(mkv(0, 32'd0,          40'h0,         1'b0, 1'b0));
        vecs.push_back(mkv(0, 32'd12345,      40'h12345,     1'b0, 1'b0));
        vecs.push_back(mkv(1, 32'd12345,      40'h2345,      1'b1, 1'b0));
        vecs.push_back(mkv(1, 32'd9999,       40'h9999,      1'b0, 1'b0));
        vecs.push_back(mkv(1, 32'd10000,      40'h0,         1'b1, 1'b0));
        vecs.push_back(mkv(2, 32'd99,         40'h99,        1'b0, 1'b0));
        vecs.push_back(mkv(2, 32'd100,        40'h0,         1'b1, 1'b0));
        vecs.push_back(mkv(2, 32'd255,        40'h55,        1'b1, 1'b0));
        vecs.push_back(mkv(3, 32'hFFFFFFFF,   40'h294967295, 1'b1, 1'b0));
        vecs.push_back(mkv(3, 32'd999999999,  40'h999999999, 1'b0, 1'b0));
        vecs.push_back(mkv(3, 32'd1000000000, 40'h0,         1'b1, 1'b0));
`endif
        foreach (vecs[i]) run_vec(vecs[i], 0, "table");

        // Result 0 held under backpressure while the next value waits on in_valid.
        accept(0, 32'd0);
        wait_done(0, lat);
        check("hold_latency", 64'(lat), 64'd17);
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        bin_a[0]      = 32'd1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_bcd c%0d", c), 64'(bcd_a[0]), 64'd0);
            check($sformatf("hold_in_ready c%0d", c), 64'(in_ready_a[0]), 64'd0);
            check($sformatf("hold_out_valid c%0d", c), 64'(out_valid_a[0]), 64'd1);
        end
        @(negedge clk);
        out_ready_a[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_a[0] = 1'b0;
        check("b2b_idle_in_ready", 64'(in_ready_a[0]), 64'd1);
        check("b2b_idle_out_valid", 64'(out_valid_a[0]), 64'd0);
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        check("b2b_second_accept", 64'(in_ready_a[0]), 64'd0);
        wait_done(0, lat);
        check("b2b_second_latency", 64'(lat), 64'd17);
        check("b2b_second_bcd", 64'(bcd_a[0]), 64'h00001);
        handshake(0);

        // Asynchronous reset between edges in the seventh SHIFT cycle.
        accept(0, 32'd54321);
        repeat (6) @(posedge clk);
        #3;
        check("midshift_busy", 64'(in_ready_a[0]), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midshift_rst_in_ready", 64'(in_ready_a[0]), 64'd1);
        check("midshift_rst_out_valid", 64'(out_valid_a[0]), 64'd0);
        check("midshift_rst_bcd", 64'(bcd_a[0]), 64'd0);
        check("midshift_rst_ovf", 64'(overflow_a[0]), 64'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        in_valid_a[0] = 1'b1;
        bin_a[0]      = 32'd4095;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        check("accept_after_reset", 64'(in_ready_a[0]), 64'd0);
        wait_done(0, lat);
        check("post_reset_latency", 64'(lat), 64'd17);
        check("post_reset_bcd", 64'(bcd_a[0]), 64'h04095);
        check("post_reset_ovf", 64'(overflow_a[0]), 64'd0);
        handshake(0);

        for (int k = 0; k < NI; k++) begin
            int n;
            n = (W_A[k] == 8) ? 1000 : 600;
            for (int i = 0; i < n; i++) begin
                t.k = k;
                t.v = $urandom & 32'((64'd1 << W_A[k]) - 64'd1);
                if (i == 0) t.v = 32'((64'd1 << W_A[k]) - 64'd1);
                model(k, t.v, t.bcd, t.ovf, t.neg);
                run_vec(t, int'($urandom_range(0, 2)), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
